// File: rtl/pll_ctrl_seq_if.sv
// Request, configuration and PLL-side signal bundle for the PLL_TOP supervisor.
// The master side issues requests and observes status; the slave side is the supervisor.
interface pll_ctrl_seq_if;
    logic       start;
    logic       stop;
    logic [5:0] cfg_div;
    logic [2:0] cfg_cp;
    logic       cfg_ibias;
    logic       cfg_bypass;
    logic       lock_det;

    logic       PLL_RESET;
    logic       PLL_BYPASS;
    logic [5:0] r_div;
    logic [2:0] r_cp;
    logic       r_ibias_cp;
    logic       clk_sel;
    logic       locked;
    logic       busy;
    logic       fault;
    logic [1:0] fault_code;
    logic [3:0] lock_loss_cnt;
    logic [2:0] state;

    modport master (
        output start, stop, cfg_div, cfg_cp, cfg_ibias, cfg_bypass, lock_det,
        input  PLL_RESET, PLL_BYPASS, r_div, r_cp, r_ibias_cp, clk_sel, locked,
               busy, fault, fault_code, lock_loss_cnt, state
    );

    modport slave (
        input  start, stop, cfg_div, cfg_cp, cfg_ibias, cfg_bypass, lock_det,
        output PLL_RESET, PLL_BYPASS, r_div, r_cp, r_ibias_cp, clk_sel, locked,
               busy, fault, fault_code, lock_loss_cnt, state
    );
endinterface

// File: rtl/pll_ctrl_seq.sv
// Power-up, configuration and lock supervisor for the PLL_TOP macro, clocked by REFCLK.
// Configuration is only driven onto the PLL while it is held in reset; clk_sel follows qualified lock.
module pll_ctrl_seq #(
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_CYCLES  = 8192,
    parameter int LOCK_CONFIRM = 4,
    parameter int MAX_RETRY    = 3,
    parameter int DIV_MIN      = 4,
    parameter int DIV_MAX      = 48
) (
    input logic           REFCLK,
    input logic           RESET,
    pll_ctrl_seq_if.slave bus
);

    localparam int CONF_W  = (LOCK_CONFIRM < 2) ? 1 : $clog2(LOCK_CONFIRM);
    localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    localparam logic [15:0]        RST_LAST  = 16'(RST_CYCLES - 1);
    localparam logic [15:0]        LOCK_LAST = 16'(LOCK_CYCLES - 1);
    localparam logic [CONF_W-1:0]  CONF_LAST = CONF_W'(LOCK_CONFIRM - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);
    localparam logic [5:0]         DIV_MIN_V = 6'(DIV_MIN);
    localparam logic [5:0]         DIV_MAX_V = 6'(DIV_MAX);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RST    = 3'd1,
        S_WAIT   = 3'd2,
        S_LOCKED = 3'd3,
        S_BYPASS = 3'd4,
        S_FAULT  = 3'd5
    } state_e;

    state_e             state_q, state_d;
    logic [15:0]        cnt_q, cnt_d;
    logic [CONF_W-1:0]  conf_q, conf_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic               sync1_q, sync1_d;
    logic               sync2_q, sync2_d;
    logic [5:0]         div_q, div_d;
    logic [2:0]         cp_q, cp_d;
    logic               ibias_q, ibias_d;
    logic [1:0]         fault_code_q, fault_code_d;
    logic [3:0]         loss_q, loss_d;
    logic               pll_reset_q, pll_reset_d;
    logic               pll_bypass_q, pll_bypass_d;
    logic               clk_sel_q, clk_sel_d;
    logic               locked_q, locked_d;
    logic               busy_q, busy_d;
    logic               fault_q, fault_d;

    logic [5:0]         eff_div;
    logic               div_ok;

    always_comb begin
        // NOTE: every signal written here gets a default first so no path can infer a latch.
        state_d      = state_q;
        cnt_d        = cnt_q;
        conf_d       = conf_q;
        retry_d      = retry_q;
        div_d        = div_q;
        cp_d         = cp_q;
        ibias_d      = ibias_q;
        fault_code_d = fault_code_q;
        loss_d       = loss_q;
        eff_div      = (bus.cfg_div == 6'd0) ? 6'd10 : bus.cfg_div;
        div_ok       = (eff_div >= DIV_MIN_V) && (eff_div <= DIV_MAX_V);

        // A lock indication is only meaningful once the PLL is out of reset, so a stale high
        // from before release cannot shortcut the synchronizer-plus-confirm qualification.
        sync1_d = bus.lock_det & ~pll_reset_q;
        sync2_d = sync1_q;

        if (bus.stop) begin
            state_d      = S_IDLE;
            fault_code_d = 2'b00;
        end else if (bus.start) begin
            retry_d      = '0;
            cnt_d        = '0;
            conf_d       = '0;
            fault_code_d = 2'b00;
            if (!div_ok) begin
                state_d      = S_FAULT;
                fault_code_d = 2'b01;
            end else if (bus.cfg_bypass) begin
                state_d = S_BYPASS;
            end else begin
                state_d = S_RST;
                div_d   = eff_div;
                cp_d    = bus.cfg_cp;
                ibias_d = bus.cfg_ibias;
            end
        end else begin
            unique case (state_q)
                S_RST: begin
                    cnt_d = cnt_q + 16'd1;
                    if (cnt_q == RST_LAST) begin
                        state_d = S_WAIT;
                        cnt_d   = '0;
                        conf_d  = '0;
                    end
                end
                S_WAIT: begin
                    cnt_d  = cnt_q + 16'd1;
                    conf_d = sync2_q ? conf_q + 1'b1 : '0;
                    // Confirmation is tested first so it wins over a coincident timeout.
                    if (sync2_q && (conf_q == CONF_LAST)) begin
                        state_d = S_LOCKED;
                    end else if (cnt_q == LOCK_LAST) begin
                        cnt_d  = '0;
                        conf_d = '0;
                        if (retry_q < RETRY_MAX) begin
                            retry_d = retry_q + 1'b1;
                            state_d = S_RST;
                        end else begin
                            state_d      = S_FAULT;
                            fault_code_d = 2'b10;
                        end
                    end
                end
                S_LOCKED: begin
                    if (!sync2_q) begin
                        state_d = S_RST;
                        cnt_d   = '0;
                        conf_d  = '0;
                        retry_d = '0;
                        if (loss_q != 4'hF) loss_d = loss_q + 4'd1;
                    end
                end
                default: ;
            endcase
        end

        // Status outputs are decoded from the next state so they register alongside it.
        pll_reset_d  = !((state_d == S_WAIT) || (state_d == S_LOCKED));
        pll_bypass_d = (state_d == S_BYPASS);
        clk_sel_d    = (state_d == S_LOCKED);
        locked_d     = (state_d == S_LOCKED);
        busy_d       = (state_d == S_RST) || (state_d == S_WAIT);
        fault_d      = (state_d == S_FAULT);
    end

    always_ff @(posedge REFCLK) begin
        // NOTE: non-blocking assignments only, so every flop samples the pre-edge values.
        if (RESET) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            conf_q       <= '0;
            retry_q      <= '0;
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            div_q        <= 6'd10;
            cp_q         <= 3'd4;
            ibias_q      <= 1'b0;
            fault_code_q <= 2'b00;
            loss_q       <= 4'd0;
            pll_reset_q  <= 1'b1;
            pll_bypass_q <= 1'b0;
            clk_sel_q    <= 1'b0;
            locked_q     <= 1'b0;
            busy_q       <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            conf_q       <= conf_d;
            retry_q      <= retry_d;
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            div_q        <= div_d;
            cp_q         <= cp_d;
            ibias_q      <= ibias_d;
            fault_code_q <= fault_code_d;
            loss_q       <= loss_d;
            pll_reset_q  <= pll_reset_d;
            pll_bypass_q <= pll_bypass_d;
            clk_sel_q    <= clk_sel_d;
            locked_q     <= locked_d;
            busy_q       <= busy_d;
            fault_q      <= fault_d;
        end
    end

    assign bus.PLL_RESET     = pll_reset_q;
    assign bus.PLL_BYPASS    = pll_bypass_q;
    assign bus.r_div         = div_q;
    assign bus.r_cp          = cp_q;
    assign bus.r_ibias_cp    = ibias_q;
    assign bus.clk_sel       = clk_sel_q;
    assign bus.locked        = locked_q;
    assign bus.busy          = busy_q;
    assign bus.fault         = fault_q;
    assign bus.fault_code    = fault_code_q;
    assign bus.lock_loss_cnt = loss_q;
    assign bus.state         = state_q;

endmodule
